// File: rtl/lzw_code_assign.sv
// LZW dictionary code assignment: hash lookups, code allocation on miss,
// full-RAM clear sweep after reset or on request.
module lzw_code_assign (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [11:0] req_addr,
    output logic        rsp_valid,
    output logic        rsp_hit,
    output logic [12:0] rsp_code,
    input  logic        clear_start,
    output logic        clear_busy,
    output logic        dict_full,
    output logic        ram_en,
    output logic        ram_wr,
    output logic [12:0] ram_addr,
    output logic [12:0] ram_wdata,
    input  logic [12:0] ram_rdata
);

    localparam logic [12:0] FIRST_CODE = 13'd258;
    localparam logic [12:0] MAX_CODE   = 13'd4095;

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        READ,
        EVAL,
        WRITE
    } state_t;

    state_t      state;
    logic [12:0] next_code;
    logic        clr_pend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= CLEAR;
            next_code  <= FIRST_CODE;
            clr_pend   <= 1'b0;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_hit    <= 1'b0;
            rsp_code   <= '0;
            clear_busy <= 1'b1;
            dict_full  <= 1'b0;
            ram_en     <= 1'b0;
            ram_wr     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (clear_start && state != CLEAR)
                clr_pend <= 1'b1;
            unique case (state)
                CLEAR: begin
                    if (ram_en && ram_addr[11:0] == 12'hFFF) begin
                        ram_en     <= 1'b0;
                        ram_wr     <= 1'b0;
                        next_code  <= FIRST_CODE;
                        dict_full  <= 1'b0;
                        clear_busy <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        ram_en    <= 1'b1;
                        ram_wr    <= 1'b1;
                        ram_wdata <= '0;
                        // ram_en low means the sweep has not started yet
                        ram_addr  <= ram_en ? ram_addr + 13'd1 : 13'd0;
                    end
                end
                IDLE: begin
                    ram_en <= 1'b0;
                    ram_wr <= 1'b0;
                    if (clr_pend || clear_start) begin
                        clr_pend   <= 1'b0;
                        clear_busy <= 1'b1;
                        req_ready  <= 1'b0;
                        ram_en     <= 1'b1;
                        ram_wr     <= 1'b1;
                        ram_wdata  <= '0;
                        ram_addr   <= '0;
                        state      <= CLEAR;
                    end else if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        ram_en    <= 1'b1;
                        ram_addr  <= {1'b0, req_addr};
                        state     <= READ;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                READ: begin
                    ram_en <= 1'b0;
                    state  <= EVAL;
                end
                EVAL: begin
                    // address stays put: the bank mux follows it this cycle
                    if (ram_rdata != 13'd0) begin
                        rsp_valid <= 1'b1;
                        rsp_hit   <= 1'b1;
                        rsp_code  <= ram_rdata;
                        state     <= IDLE;
                    end else if (!dict_full) begin
                        state <= WRITE;
                    end else begin
                        rsp_valid <= 1'b1;
                        rsp_hit   <= 1'b0;
                        rsp_code  <= '0;
                        state     <= IDLE;
                    end
                end
                WRITE: begin
                    ram_en    <= 1'b1;
                    ram_wr    <= 1'b1;
                    ram_wdata <= next_code;
                    rsp_valid <= 1'b1;
                    rsp_hit   <= 1'b0;
                    rsp_code  <= next_code;
                    if (next_code == MAX_CODE)
                        dict_full <= 1'b1;
                    else
                        next_code <= next_code + 13'd1;
                    state <= IDLE;
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule
